// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl
//   Step controller for a grid snake game. It paces head moves with a
//   speed-scaled tick, latches button presses into a pending direction, and
//   computes the next head cell. It applies the wall rule, runs a
//   request/acknowledge handshake with the body unit, and tracks the score
//   and game-over state.
//
// Ports
//   Clk                 system clock, all state changes on rising edge
//   Rst                 synchronous reset, active-low
//   i_Push[3:0]         buttons, active-low: 0 up, 1 down, 2 left, 3 right
//   i_Start             start / restart request (level)
//   i_Speed[2:0]        speed level, 7 fastest
//   i_Food_x/i_Food_y   current food cell
//   i_Step_ack          body unit accepted the step (one-cycle pulse)
//   i_Body_hit          with i_Step_ack: new head overlaps body
//   o_Head_x/o_Head_y   committed head cell
//   o_Way               committed direction (0 up, 1 down, 2 left, 3 right)
//   o_Step              step request; o_Nxt_x/o_Nxt_y carry the proposed head
//   o_Grow              qualifies o_Step: body lengthens on this step
//   o_Eat               one-cycle pulse after a committed food step
//   o_Score             food count, saturating at 255
//   o_Over              game-over level
module snake_step_ctrl #(
  parameter logic [23:0] TICK_BASE = 24'd625000,
  parameter int          GRID_X    = 40,
  parameter int          GRID_Y    = 30
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] i_Push,
  input  logic       i_Start,
  input  logic [2:0] i_Speed,
  input  logic [5:0] i_Food_x,
  input  logic [5:0] i_Food_y,
  input  logic       i_Step_ack,
  input  logic       i_Body_hit,
  output logic [5:0] o_Head_x,
  output logic [5:0] o_Head_y,
  output logic [1:0] o_Way,
  output logic       o_Step,
  output logic [5:0] o_Nxt_x,
  output logic [5:0] o_Nxt_y,
  output logic       o_Grow,
  output logic       o_Eat,
  output logic [7:0] o_Score,
  output logic       o_Over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_CALC,
    S_SHIFT,
    S_OVER
  } state_t;

  localparam logic [5:0] HOME_X = 6'(GRID_X / 2);
  localparam logic [5:0] HOME_Y = 6'(GRID_Y / 2);
  localparam logic [5:0] MAX_X  = 6'(GRID_X - 1);
  localparam logic [5:0] MAX_Y  = 6'(GRID_Y - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t      state_q,  state_d;
  logic [23:0] cnt_q,    cnt_d;
  logic [5:0]  head_x_q, head_x_d;
  logic [5:0]  head_y_q, head_y_d;
  logic [1:0]  way_q,    way_d;
  logic [1:0]  pend_q,   pend_d;
  logic [1:0]  apply_q,  apply_d;   // direction used in CALC, committed on ack
  logic [5:0]  nxt_x_q,  nxt_x_d;
  logic [5:0]  nxt_y_q,  nxt_y_d;
  logic        grow_q,   grow_d;
  logic        eat_q,    eat_d;
  logic [7:0]  score_q,  score_d;

  // Move period: TICK_BASE * (8 - speed) clocks. The product needs at most
  // 27 bits, so compare in that width to avoid silent truncation.
  logic [3:0]  speed_mult;
  logic [26:0] tick_lim;
  logic        tick_hit;

  assign speed_mult = 4'd8 - {1'b0, i_Speed};
  assign tick_lim   = {3'd0, TICK_BASE} * {23'd0, speed_mult};
  assign tick_hit   = ({3'd0, cnt_q} == (tick_lim - 27'd1));

  // Button decode: the lowest-index pressed (low) bit wins.
  logic       press_vld;
  logic [1:0] press_dir;

  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_UP;
    if (!i_Push[0])      press_dir = DIR_UP;
    else if (!i_Push[1]) press_dir = DIR_DOWN;
    else if (!i_Push[2]) press_dir = DIR_LEFT;
    else if (!i_Push[3]) press_dir = DIR_RIGHT;
    else                 press_vld = 1'b0;
  end

  // Candidate head from the pending direction, with the no-wrap wall check.
  logic [5:0] calc_x;
  logic [5:0] calc_y;
  logic       calc_wall;

  always_comb begin
    calc_x    = head_x_q;
    calc_y    = head_y_q;
    calc_wall = 1'b0;
    case (pend_q)
      DIR_UP: begin
        if (head_y_q == 6'd0) calc_wall = 1'b1;
        else                  calc_y    = head_y_q - 6'd1;
      end
      DIR_DOWN: begin
        if (head_y_q == MAX_Y) calc_wall = 1'b1;
        else                   calc_y    = head_y_q + 6'd1;
      end
      DIR_LEFT: begin
        if (head_x_q == 6'd0) calc_wall = 1'b1;
        else                  calc_x    = head_x_q - 6'd1;
      end
      default: begin
        if (head_x_q == MAX_X) calc_wall = 1'b1;
        else                   calc_x    = head_x_q + 6'd1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    way_d    = way_q;
    pend_d   = pend_q;
    apply_d  = apply_q;
    nxt_x_d  = nxt_x_q;
    nxt_y_d  = nxt_y_q;
    grow_d   = grow_q;
    eat_d    = 1'b0;
    score_d  = score_q;

    // Up/down and left/right codes differ only in bit 0, so a reversal of
    // the committed direction is exactly an XOR of 2'b01.
    if (state_q != S_OVER && press_vld && ((press_dir ^ way_q) != 2'b01)) begin
      pend_d = press_dir;
    end

    case (state_q)
      S_IDLE: begin
        if (i_Start) state_d = S_WAIT_TICK;
      end

      S_WAIT_TICK: begin
        if (tick_hit) state_d = S_CALC;
        else          cnt_d   = cnt_q + 24'd1;
      end

      S_CALC: begin
        apply_d = pend_q;
        if (calc_wall) begin
          grow_d  = 1'b0;
          state_d = S_OVER;
        end else begin
          nxt_x_d = calc_x;
          nxt_y_d = calc_y;
          grow_d  = (calc_x == i_Food_x) && (calc_y == i_Food_y);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (i_Step_ack) begin
          grow_d = 1'b0;
          if (i_Body_hit) begin
            state_d = S_OVER;
          end else begin
            head_x_d = nxt_x_q;
            head_y_d = nxt_y_q;
            way_d    = apply_q;
            if (grow_q) begin
              eat_d = 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
            state_d = S_WAIT_TICK;
          end
        end
      end

      S_OVER: begin
        if (i_Start) begin
          head_x_d = HOME_X;
          head_y_d = HOME_Y;
          way_d    = DIR_RIGHT;
          pend_d   = DIR_RIGHT;
          apply_d  = DIR_RIGHT;
          nxt_x_d  = HOME_X;
          nxt_y_d  = HOME_Y;
          grow_d   = 1'b0;
          score_d  = 8'd0;
          state_d  = S_WAIT_TICK;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      head_x_q <= HOME_X;
      head_y_q <= HOME_Y;
      way_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      apply_q  <= DIR_RIGHT;
      nxt_x_q  <= HOME_X;
      nxt_y_q  <= HOME_Y;
      grow_q   <= 1'b0;
      eat_q    <= 1'b0;
      score_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      way_q    <= way_d;
      pend_q   <= pend_d;
      apply_q  <= apply_d;
      nxt_x_q  <= nxt_x_d;
      nxt_y_q  <= nxt_y_d;
      grow_q   <= grow_d;
      eat_q    <= eat_d;
      score_q  <= score_d;
    end
  end

  assign o_Head_x = head_x_q;
  assign o_Head_y = head_y_q;
  assign o_Way    = way_q;
  assign o_Step   = (state_q == S_SHIFT);
  assign o_Nxt_x  = nxt_x_q;
  assign o_Nxt_y  = nxt_y_q;
  assign o_Grow   = grow_q;
  assign o_Eat    = eat_q;
  assign o_Score  = score_q;
  assign o_Over   = (state_q == S_OVER);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Testbench for snake_step_ctrl: scripted vector table, hand-written corner
// sequences and a randomized phase checked against a game-level model.
module tb_snake_step_ctrl;

  localparam int GX = 40;
  localparam int GY = 30;

  logic       Clk;
  logic       Rst;
  logic [3:0] i_Push;
  logic       i_Start;
  logic [2:0] i_Speed;
  logic [5:0] i_Food_x;
  logic [5:0] i_Food_y;
  logic       i_Step_ack;
  logic       i_Body_hit;
  logic [5:0] o_Head_x;
  logic [5:0] o_Head_y;
  logic [1:0] o_Way;
  logic       o_Step;
  logic [5:0] o_Nxt_x;
  logic [5:0] o_Nxt_y;
  logic       o_Grow;
  logic       o_Eat;
  logic [7:0] o_Score;
  logic       o_Over;

  snake_step_ctrl #(
    .TICK_BASE (24'd4),
    .GRID_X    (GX),
    .GRID_Y    (GY)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_Push     (i_Push),
    .i_Start    (i_Start),
    .i_Speed    (i_Speed),
    .i_Food_x   (i_Food_x),
    .i_Food_y   (i_Food_y),
    .i_Step_ack (i_Step_ack),
    .i_Body_hit (i_Body_hit),
    .o_Head_x   (o_Head_x),
    .o_Head_y   (o_Head_y),
    .o_Way      (o_Way),
    .o_Step     (o_Step),
    .o_Nxt_x    (o_Nxt_x),
    .o_Nxt_y    (o_Nxt_y),
    .o_Grow     (o_Grow),
    .o_Eat      (o_Eat),
    .o_Score    (o_Score),
    .o_Over     (o_Over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  // Game-level reference model.
  int m_x, m_y, m_way, m_pend, m_score;
  bit m_over;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_home();
    m_x = GX / 2; m_y = GY / 2; m_way = 3; m_pend = 3; m_score = 0; m_over = 0;
  endtask

  task automatic model_next(output int nx, output int ny, output bit wall);
    nx = m_x; ny = m_y;
    case (m_pend)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    wall = (nx < 0) || (nx >= GX) || (ny < 0) || (ny >= GY);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; tick(); tick(); Rst = 1'b1;
    model_home();
  endtask

  task automatic do_start();
    i_Start = 1'b1; tick(); i_Start = 1'b0;
    if (m_over) model_home();
  endtask

  // One-cycle press; model applies the first pressed button unless it
  // reverses the committed heading.
  task automatic press(input logic [3:0] p);
    logic [3:0] pv;
    int d;
    pv = p;
    i_Push = pv; tick(); i_Push = 4'hF;
    d = -1;
    for (int k = 3; k >= 0; k--) if (!pv[k]) d = k;
    if (!m_over && d >= 0) begin
      if (!((d == 0 && m_way == 1) || (d == 1 && m_way == 0) ||
            (d == 2 && m_way == 3) || (d == 3 && m_way == 2)))
        m_pend = d;
    end
  endtask

  task automatic set_food_next();
    int nx, ny; bit wall;
    model_next(nx, ny, wall);
    if (!wall) begin
      i_Food_x = 6'(nx); i_Food_y = 6'(ny);
    end
  endtask

  // Wait for the next move outcome, check it, acknowledge after dly cycles.
  task automatic run_step(input bit hit, input int dly, input string tag);
    int nx, ny, n;
    bit wall, grow;
    model_next(nx, ny, wall);
    grow = !wall && (nx == int'(i_Food_x)) && (ny == int'(i_Food_y));
    n = 0;
    while (!o_Step && !o_Over && n < 200) begin
      tick(); n++;
    end
    step_no++;
    chk({tag, "_timeout"}, (n < 200) ? 1 : 0, 1);
    if (wall) begin
      chk({tag, "_wall_over"}, int'(o_Over), 1);
      chk({tag, "_wall_nostep"}, int'(o_Step), 0);
      chk({tag, "_wall_hx"}, int'(o_Head_x), m_x);
      chk({tag, "_wall_hy"}, int'(o_Head_y), m_y);
      m_over = 1;
    end else begin
      chk({tag, "_step"}, int'(o_Step), 1);
      chk({tag, "_nxt_x"}, int'(o_Nxt_x), nx);
      chk({tag, "_nxt_y"}, int'(o_Nxt_y), ny);
      chk({tag, "_grow"}, int'(o_Grow), int'(grow));
      for (int k = 0; k < dly; k++) begin
        tick();
        chk({tag, "_hold_step"}, int'(o_Step), 1);
        chk({tag, "_hold_nxt"}, int'({o_Nxt_x, o_Nxt_y, o_Grow}),
            (nx << 7) | (ny << 1) | int'(grow));
      end
      i_Step_ack = 1'b1; i_Body_hit = hit; tick();
      i_Step_ack = 1'b0; i_Body_hit = 1'b0;
      chk({tag, "_step_drop"}, int'(o_Step), 0);
      if (hit) begin
        m_over = 1;
        chk({tag, "_hit_over"}, int'(o_Over), 1);
        chk({tag, "_hit_noeat"}, int'(o_Eat), 0);
      end else begin
        m_x = nx; m_y = ny; m_way = m_pend;
        if (grow && m_score < 255) m_score++;
        chk({tag, "_over0"}, int'(o_Over), 0);
        chk({tag, "_eat"}, int'(o_Eat), int'(grow));
      end
      chk({tag, "_hx"}, int'(o_Head_x), m_x);
      chk({tag, "_hy"}, int'(o_Head_y), m_y);
      chk({tag, "_way"}, int'(o_Way), m_way);
      chk({tag, "_score"}, int'(o_Score), m_score);
      if (!hit) begin
        tick();
        chk({tag, "_eat_pulse"}, int'(o_Eat), 0);
      end
    end
    $display("step %0d %s: head=(%0d,%0d) way=%0d score=%0d over=%0d",
             step_no, tag, o_Head_x, o_Head_y, o_Way, o_Score, o_Over);
  endtask

  typedef struct {
    logic [3:0] push;
    int fx, fy, hit, dly;
    int ex, ey, eway, escore, eover;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sq[4];
    int n;

    Rst = 1'b0; i_Push = 4'hF; i_Start = 1'b0; i_Speed = 3'd7;
    i_Food_x = 6'd0; i_Food_y = 6'd0; i_Step_ack = 1'b0; i_Body_hit = 1'b0;

    vecs[0] = '{4'hF,    21, 15, 0, 0,  21, 15, 3, 1, 0};
    vecs[1] = '{4'b1011,  0,  0, 0, 0,  22, 15, 3, 1, 0};
    vecs[2] = '{4'b1110,  0,  0, 0, 2,  22, 14, 0, 1, 0};
    vecs[3] = '{4'b1101,  0,  0, 0, 0,  22, 13, 0, 1, 0};
    vecs[4] = '{4'b0111, 23, 13, 0, 1,  23, 13, 3, 2, 0};
    vecs[5] = '{4'b1001,  0,  0, 0, 0,  23, 14, 1, 2, 0};
    vecs[6] = '{4'hF,     0,  0, 1, 50, 23, 14, 1, 2, 1};

    do_reset();
    chk("rst_hx", int'(o_Head_x), 20);
    chk("rst_hy", int'(o_Head_y), 15);
    chk("rst_way", int'(o_Way), 3);
    chk("rst_step", int'(o_Step), 0);
    chk("rst_grow", int'(o_Grow), 0);
    chk("rst_eat", int'(o_Eat), 0);
    chk("rst_over", int'(o_Over), 0);
    chk("rst_score", int'(o_Score), 0);
    chk("rst_nxt", int'({o_Nxt_x, o_Nxt_y}), (20 << 6) | 15);

    // Idle holds until start.
    repeat (20) tick();
    chk("idle_nostep", int'(o_Step), 0);

    // Scripted table.
    do_start();
    for (int i = 0; i < 7; i++) begin
      i_Speed = 3'd7;
      i_Food_x = 6'(vecs[i].fx); i_Food_y = 6'(vecs[i].fy);
      if (vecs[i].push != 4'hF) press(vecs[i].push);
      run_step(vecs[i].hit != 0, vecs[i].dly, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_hx", i), int'(o_Head_x), vecs[i].ex);
      chk($sformatf("vec%0d_hy", i), int'(o_Head_y), vecs[i].ey);
      chk($sformatf("vec%0d_way", i), int'(o_Way), vecs[i].eway);
      chk($sformatf("vec%0d_score", i), int'(o_Score), vecs[i].escore);
      chk($sformatf("vec%0d_over", i), int'(o_Over), vecs[i].eover);
    end

    // Game over freezes the head and ignores buttons.
    press(4'b1110);
    repeat (10) tick();
    chk("over_frozen", int'({o_Head_x, o_Head_y}), (23 << 6) | 14);
    chk("over_nostep", int'(o_Step), 0);

    // Restart, then march right into the wall.
    do_start();
    chk("restart_hx", int'(o_Head_x), 20);
    chk("restart_score", int'(o_Score), 0);
    chk("restart_over", int'(o_Over), 0);
    chk("restart_way", int'(o_Way), 3);
    i_Food_x = 6'd0; i_Food_y = 6'd0;
    for (int i = 0; i < 19; i++) run_step(1'b0, 0, "right");
    run_step(1'b0, 0, "wall");
    chk("wall_head", int'({o_Head_x, o_Head_y}), (39 << 6) | 15);
    chk("wall_over", int'(o_Over), 1);
    press(4'b1110);
    do_start();
    chk("wall_restart_head", int'({o_Head_x, o_Head_y}), (20 << 6) | 15);
    chk("wall_restart_score", int'(o_Score), 0);
    chk("wall_restart_over", int'(o_Over), 0);
    run_step(1'b0, 0, "after_restart");
    chk("after_restart_x", int'(o_Head_x), 21);

    // Reset in the middle of a step request.
    n = 0;
    while (!o_Step && n < 200) begin tick(); n++; end
    chk("mid_shift_reached", int'(o_Step), 1);
    Rst = 1'b0; tick(); Rst = 1'b1;
    chk("mid_rst_step", int'(o_Step), 0);
    i_Step_ack = 1'b1; tick(); i_Step_ack = 1'b0;
    tick();
    chk("mid_rst_late_ack_step", int'(o_Step), 0);
    chk("mid_rst_head", int'({o_Head_x, o_Head_y}), (20 << 6) | 15);
    chk("mid_rst_score", int'(o_Score), 0);
    model_home();

    // Square loop eating every cell: score saturates at 255.
    do_start();
    sq[0] = 4'b1110; sq[1] = 4'b0111; sq[2] = 4'b1101; sq[3] = 4'b1011;
    for (int i = 0; i < 256; i++) begin
      press(sq[i % 4]);
      set_food_next();
      run_step(1'b0, 0, "sq");
      if (i == 254) chk("score_255", int'(o_Score), 255);
    end
    chk("score_sat", int'(o_Score), 255);

    // Randomized play against the model.
    for (int it = 0; it < 400; it++) begin
      int np;
      if (m_over) do_start();
      i_Speed = 3'($urandom_range(7));
      np = $urandom_range(2);
      for (int k = 0; k < np; k++) press(4'($urandom_range(15)));
      if ($urandom_range(1) == 1) set_food_next();
      else begin
        i_Food_x = 6'($urandom_range(63));
        i_Food_y = 6'($urandom_range(63));
      end
      run_step($urandom_range(19) == 0, $urandom_range(4), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
